mmu_utlb: RTL and testbench

Parametrised successor to the single-cycle MMU front end. It serves N_CH independent translation channels (IF, LSU, ...), each with a private fully-associative micro-TLB (uTLB) of UTLB_DEPTH 4 KB-page entries. Misses are refilled from the shared main TLB through a round-robin arbitrated request/ack port. The block sits between the pipeline address stages and the main TLB, replacing combinational main-TLB lookups with a 1-cycle uTLB hit path.

---
 rtl/mmu_utlb.sv | 229 ++++++++++++++++++++++
 tb/tb_mmu_utlb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_utlb.sv
// Multi-channel MMU front end: a private fully-associative micro-TLB per
// channel gives a 1-cycle hit path; misses are refilled one at a time from the
// shared main TLB through a round-robin arbitrated request/ack port.
module mmu_utlb #(
   parameter int N_CH       = 2,
   parameter int UTLB_DEPTH = 4,
   parameter int ASID_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ASID_W-1:0]    asid,
   input  logic                 kseg0_uncached,
   input  logic                 is_user_mode,
   input  logic                 tlb_flush,
   input  logic [N_CH-1:0]      ch_req,
   output logic [N_CH-1:0]      ch_ready,
   input  logic [32*N_CH-1:0]   ch_vaddr,
   input  logic [N_CH-1:0]      ch_store,
   output logic [N_CH-1:0]      ch_resp_valid,
   output logic [32*N_CH-1:0]   ch_paddr,
   output logic [N_CH-1:0]      ch_uncached,
   output logic [4*N_CH-1:0]    ch_ex,
   output logic                 mtlb_req,
   output logic [19:0]          mtlb_vpn,
   input  logic                 mtlb_ack,
   input  logic                 mtlb_hit,
   input  logic [19:0]          mtlb_pfn,
   input  logic                 mtlb_v,
   input  logic                 mtlb_d,
   input  logic                 mtlb_g,
   input  logic                 mtlb_uncached
);
   localparam int PW = $clog2(UTLB_DEPTH);
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [3:0] EX_ILL = 4'b1000, EX_REFILL = 4'b0100, EX_INV = 4'b0010, EX_MOD = 4'b0001;

   typedef enum logic [1:0] {IDLE, CHECK, WAIT} st_e;

   st_e                   st_q    [N_CH], st_d    [N_CH];
   logic [31:0]           va_q    [N_CH], va_d    [N_CH];
   logic [31:0]           pa_q    [N_CH], pa_d    [N_CH];
   logic [3:0]            ex_q    [N_CH], ex_d    [N_CH];
   logic [PW-1:0]         vp_q    [N_CH], vp_d    [N_CH];
   logic [UTLB_DEPTH-1:0] ev_q    [N_CH], ev_d    [N_CH];
   logic [UTLB_DEPTH-1:0] ed_q    [N_CH], ed_d    [N_CH];
   logic [UTLB_DEPTH-1:0] eg_q    [N_CH], eg_d    [N_CH];
   logic [UTLB_DEPTH-1:0] eu_q    [N_CH], eu_d    [N_CH];
   logic [19:0]           evpn_q  [N_CH][UTLB_DEPTH], evpn_d  [N_CH][UTLB_DEPTH];
   logic [19:0]           epfn_q  [N_CH][UTLB_DEPTH], epfn_d  [N_CH][UTLB_DEPTH];
   logic [ASID_W-1:0]     easid_q [N_CH][UTLB_DEPTH], easid_d [N_CH][UTLB_DEPTH];
   logic [N_CH-1:0]       store_q, store_d, rv_q, rv_d, unc_q, unc_d;
   logic                  busy_q, busy_d, flp_q, flp_d;
   logic [CW-1:0]         gnt_q, gnt_d, rr_q, rr_d;

   // Channel FSMs, uTLB lookup/fill, flush and refill arbitration
   always_comb begin : p_next
      logic          hit, done, found;
      logic [PW-1:0] hidx, fidx;
      logic [31:0]   va;
      int            idx;
      st_d = st_q;  va_d = va_q;  pa_d = pa_q;  ex_d = ex_q;  vp_d = vp_q;
      ev_d = ev_q;  ed_d = ed_q;  eg_d = eg_q;  eu_d = eu_q;
      evpn_d = evpn_q;  epfn_d = epfn_q;  easid_d = easid_q;
      store_d = store_q;  rv_d = '0;  unc_d = unc_q;
      busy_d = busy_q;  flp_d = flp_q;  gnt_d = gnt_q;  rr_d = rr_q;
      ch_ready = '0;
      for (int i = 0; i < N_CH; i++) begin
         va   = va_q[i];
         done = 1'b0;
         hit  = 1'b0;
         hidx = '0;
         fidx = vp_q[i];
         // descending scans so the lowest matching / free entry wins
         for (int e = UTLB_DEPTH-1; e >= 0; e--) begin
            if (ev_q[i][e] && evpn_q[i][e] == va[31:12] && (eg_q[i][e] || easid_q[i][e] == asid)) begin
               hit  = 1'b1;
               hidx = PW'(e);
            end
            if (!ev_q[i][e]) fidx = PW'(e);
         end
         case (st_q[i])
            IDLE: done = 1'b1;
            CHECK: begin
               done     = 1'b1;
               rv_d[i]  = 1'b1;
               pa_d[i]  = '0;
               unc_d[i] = 1'b0;
               ex_d[i]  = '0;
               if (is_user_mode && va[31]) begin
                  ex_d[i] = EX_ILL;
               end else if (va[31:30] == 2'b10) begin
                  pa_d[i]  = {3'b000, va[28:0]};
                  unc_d[i] = (va[31:29] == 3'b101) || (kseg0_uncached && va[31:29] == 3'b100);
               end else if (hit) begin
                  pa_d[i]  = {epfn_q[i][hidx], va[11:0]};
                  unc_d[i] = eu_q[i][hidx];
                  if (store_q[i] && !ed_q[i][hidx]) ex_d[i] = EX_MOD;
               end else begin
                  done     = 1'b0;
                  rv_d[i]  = 1'b0;
                  pa_d[i]  = pa_q[i];
                  unc_d[i] = unc_q[i];
                  ex_d[i]  = ex_q[i];
                  st_d[i]  = WAIT;
               end
            end
            WAIT: begin
               if (busy_q && gnt_q == CW'(i) && mtlb_ack) begin
                  st_d[i]  = IDLE;
                  rv_d[i]  = 1'b1;
                  pa_d[i]  = '0;
                  unc_d[i] = 1'b0;
                  ex_d[i]  = '0;
                  if (!mtlb_hit) ex_d[i] = EX_REFILL;
                  else if (!mtlb_v) ex_d[i] = EX_INV;
                  else begin
                     pa_d[i]  = {mtlb_pfn, va[11:0]};
                     unc_d[i] = mtlb_uncached;
                     if (store_q[i] && !mtlb_d) ex_d[i] = EX_MOD;
                     // a flush seen while the lookup was in flight makes the result stale
                     if (!(tlb_flush || flp_q)) begin
                        ev_d[i][fidx]    = 1'b1;
                        ed_d[i][fidx]    = mtlb_d;
                        eg_d[i][fidx]    = mtlb_g;
                        eu_d[i][fidx]    = mtlb_uncached;
                        evpn_d[i][fidx]  = va[31:12];
                        epfn_d[i][fidx]  = mtlb_pfn;
                        easid_d[i][fidx] = asid;
                        vp_d[i]          = vp_q[i] + PW'(1);
                     end
                  end
               end
            end
            default: st_d[i] = IDLE;
         endcase
         if (done) begin
            ch_ready[i] = 1'b1;
            if (ch_req[i]) begin
               va_d[i]    = ch_vaddr[32*i +: 32];
               store_d[i] = ch_store[i];
               st_d[i]    = CHECK;
            end else begin
               st_d[i] = IDLE;
            end
         end
      end
      if (tlb_flush) for (int i = 0; i < N_CH; i++) ev_d[i] = '0;
      // single outstanding lookup; round-robin grant starting at rr_q
      if (busy_q) begin
         if (tlb_flush) flp_d = 1'b1;
         if (mtlb_ack) begin
            busy_d = 1'b0;
            flp_d  = 1'b0;
         end
      end else begin
         found = 1'b0;
         for (int k = 0; k < N_CH; k++) begin
            idx = (int'(rr_q) + k) % N_CH;
            if (!found && st_q[idx] == WAIT) begin
               found  = 1'b1;
               busy_d = 1'b1;
               flp_d  = 1'b0;
               gnt_d  = CW'(idx);
               rr_d   = CW'((idx + 1) % N_CH);
            end
         end
      end
   end

   // Control state, valid bits and response registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_CH; i++) begin
            st_q[i] <= IDLE;
            va_q[i] <= '0;
            pa_q[i] <= '0;
            ex_q[i] <= '0;
            vp_q[i] <= '0;
            ev_q[i] <= '0;
         end
         store_q <= '0;
         rv_q    <= '0;
         unc_q   <= '0;
         busy_q  <= 1'b0;
         flp_q   <= 1'b0;
         gnt_q   <= '0;
         rr_q    <= '0;
      end else begin
         st_q    <= st_d;
         va_q    <= va_d;
         pa_q    <= pa_d;
         ex_q    <= ex_d;
         vp_q    <= vp_d;
         ev_q    <= ev_d;
         store_q <= store_d;
         rv_q    <= rv_d;
         unc_q   <= unc_d;
         busy_q  <= busy_d;
         flp_q   <= flp_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
      end
   end

   // Entry payload is only meaningful under its valid bit, so it needs no reset
   always_ff @(posedge clk) begin
      ed_q    <= ed_d;
      eg_q    <= eg_d;
      eu_q    <= eu_d;
      evpn_q  <= evpn_d;
      epfn_q  <= epfn_d;
      easid_q <= easid_d;
   end

   // Flatten per-channel results and select the granted VPN
   always_comb begin
      mtlb_vpn = '0;
      for (int i = 0; i < N_CH; i++) begin
         ch_paddr[32*i +: 32] = pa_q[i];
         ch_ex[4*i +: 4]      = ex_q[i];
         if (gnt_q == CW'(i)) mtlb_vpn = va_q[i][31:12];
      end
   end

   assign ch_resp_valid = rv_q;
   assign ch_uncached   = unc_q;
   assign mtlb_req      = busy_q;

endmodule

// File: tb/tb_mmu_utlb.sv
// Bench for mmu_utlb: table of translation vectors plus hand sequences for
// streaming, flush races, reset during refill, replacement and arbitration.
module tb_mmu_utlb;
   localparam int NCH = 2;
   localparam logic [3:0] ILL = 4'b1000, REF = 4'b0100, INV = 4'b0010, MOD = 4'b0001;

   logic clk, reset, kseg0_uncached, is_user_mode, tlb_flush;
   logic [7:0] asid;
   logic [NCH-1:0] ch_req, ch_ready, ch_store, ch_resp_valid, ch_uncached;
   logic [32*NCH-1:0] ch_vaddr, ch_paddr;
   logic [4*NCH-1:0] ch_ex;
   logic mtlb_req, mtlb_ack, mtlb_hit, mtlb_v, mtlb_d, mtlb_g, mtlb_uncached;
   logic [19:0] mtlb_vpn, mtlb_pfn;

   mmu_utlb #(.N_CH(NCH), .UTLB_DEPTH(4), .ASID_W(8)) dut (
      .clk(clk), .reset(reset), .asid(asid), .kseg0_uncached(kseg0_uncached),
      .is_user_mode(is_user_mode), .tlb_flush(tlb_flush), .ch_req(ch_req),
      .ch_ready(ch_ready), .ch_vaddr(ch_vaddr), .ch_store(ch_store),
      .ch_resp_valid(ch_resp_valid), .ch_paddr(ch_paddr), .ch_uncached(ch_uncached),
      .ch_ex(ch_ex), .mtlb_req(mtlb_req), .mtlb_vpn(mtlb_vpn), .mtlb_ack(mtlb_ack),
      .mtlb_hit(mtlb_hit), .mtlb_pfn(mtlb_pfn), .mtlb_v(mtlb_v), .mtlb_d(mtlb_d),
      .mtlb_g(mtlb_g), .mtlb_uncached(mtlb_uncached));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int ch; logic [31:0] va; logic st, user, k0u; logic [7:0] asid;
      logic miss, mh; logic [19:0] pfn; logic v, d, g, u;
      logic [31:0] pa; logic unc; logic [3:0] ex;
   } vec_t;

   typedef struct {
      int ch; logic [31:0] pa; logic unc; logic [3:0] ex; int due;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0, n_err = 0, cyc = 0;
   vec_t tbl[17];

   function automatic vec_t mv(int ch, logic [31:0] va, logic st, logic user, logic k0u,
                               logic [7:0] a, logic miss, logic mh, logic [19:0] pfn,
                               logic v, logic d, logic g, logic u,
                               logic [31:0] pa, logic unc, logic [3:0] ex);
      vec_t r;
      r.ch = ch; r.va = va; r.st = st; r.user = user; r.k0u = k0u; r.asid = a;
      r.miss = miss; r.mh = mh; r.pfn = pfn; r.v = v; r.d = d; r.g = g; r.u = u;
      r.pa = pa; r.unc = unc; r.ex = ex;
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic push_exp(int c, logic [31:0] pa, logic unc, logic [3:0] ex, int due);
      exp_t e;
      e.ch = c; e.pa = pa; e.unc = unc; e.ex = ex; e.due = due;
      sb.push_back(e);
   endtask

   // Advance to the next falling edge and score any response strobes there
   task automatic tick();
      @(negedge clk);
      cyc++;
      for (int c = 0; c < NCH; c++) begin
         if (ch_resp_valid[c]) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_resp: ch%0d paddr %h ex %b at cyc %0d", c, ch_paddr[32*c +: 32], ch_ex[4*c +: 4], cyc);
            end else begin
               exp_t e;
               logic pa_ok;
               e = sb.pop_front();
               // physical address / cacheability only carry meaning on success or mod
               pa_ok = (e.ex[3:1] != 3'b000) ||
                       (ch_paddr[32*c +: 32] == e.pa && ch_uncached[c] == e.unc);
               if (e.ch != c || e.due != cyc || ch_ex[4*c +: 4] != e.ex || !pa_ok) begin
                  n_err++;
                  $display("FAIL resp: got ch%0d cyc %0d paddr %h unc %b ex %b, expected ch%0d cyc %0d paddr %h unc %b ex %b",
                           c, cyc, ch_paddr[32*c +: 32], ch_uncached[c], ch_ex[4*c +: 4],
                           e.ch, e.due, e.pa, e.unc, e.ex);
               end
            end
         end
      end
      if (sb.size() != 0 && sb[0].due < cyc) begin
         n_cmp++;
         n_err++;
         $display("FAIL missing_resp: ch%0d expected at cyc %0d, none by cyc %0d", sb[0].ch, sb[0].due, cyc);
         void'(sb.pop_front());
      end
   endtask

   task automatic req_drive(int c, logic [31:0] va, logic st);
      chk("ch_ready", 32'(ch_ready[c]), 32'd1);
      ch_req[c] = 1'b1;
      ch_vaddr[32*c +: 32] = va;
      ch_store[c] = st;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!mtlb_req && n < 40) begin
         tick();
         n++;
      end
      n_cmp++;
      if (!mtlb_req) begin
         n_err++;
         $display("FAIL mtlb_req_timeout: got 0 expected 1 within 40 cycles (cyc %0d)", cyc);
      end
   endtask

   // Answer one main-TLB lookup; fmode 1 = flush in the ack cycle, 2 = flush while outstanding
   task automatic serve(int c, logic [31:0] va, int lat, logic mh, logic [19:0] pfn,
                        logic v, logic d, logic g, logic u,
                        logic [31:0] pa, logic unc, logic [3:0] ex, int fmode);
      wait_req();
      if (!mtlb_req) return;
      chk("mtlb_vpn", 32'(mtlb_vpn), 32'(va[31:12]));
      for (int k = 1; k < lat; k++) begin
         if (fmode == 2 && k == 1) tlb_flush = 1'b1;
         tick();
         tlb_flush = 1'b0;
         chk("mtlb_vpn_hold", {11'b0, mtlb_req, mtlb_vpn}, {12'h001, va[31:12]});
      end
      mtlb_ack = 1'b1; mtlb_hit = mh; mtlb_pfn = pfn;
      mtlb_v = v; mtlb_d = d; mtlb_g = g; mtlb_uncached = u;
      tlb_flush = (fmode == 1);
      push_exp(c, pa, unc, ex, cyc + 1);
      tick();
      mtlb_ack = 1'b0; mtlb_hit = 1'b0; mtlb_pfn = '0;
      mtlb_v = 1'b0; mtlb_d = 1'b0; mtlb_g = 1'b0; mtlb_uncached = 1'b0;
      tlb_flush = 1'b0;
   endtask

   task automatic run_vec(vec_t t, int fmode);
      is_user_mode = t.user; kseg0_uncached = t.k0u; asid = t.asid;
      req_drive(t.ch, t.va, t.st);
      if (!t.miss) push_exp(t.ch, t.pa, t.unc, t.ex, cyc + 2);
      tick();
      ch_req = '0;
      if (t.miss) begin
         serve(t.ch, t.va, 2, t.mh, t.pfn, t.v, t.d, t.g, t.u, t.pa, t.unc, t.ex, fmode);
      end else begin
         tick();
         chk("no_mtlb_req_on_hit", 32'(mtlb_req), 32'd0);
      end
      tick();
      tick();
      chk("sb_drained", sb.size(), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      chk("rst_ready", 32'(ch_ready), 32'h3);
      chk("rst_resp_valid", 32'(ch_resp_valid), 32'h0);
      chk("rst_paddr", ch_paddr[31:0] | ch_paddr[63:32], 32'h0);
      chk("rst_ex_unc", {ch_ex, ch_uncached, mtlb_req}, 32'h0);
      reset = 1'b1;
      tick();
   endtask

   initial begin
      reset = 1'b0; asid = 8'h05; kseg0_uncached = 1'b0; is_user_mode = 1'b0; tlb_flush = 1'b0;
      ch_req = '0; ch_vaddr = '0; ch_store = '0;
      mtlb_ack = 1'b0; mtlb_hit = 1'b0; mtlb_pfn = '0;
      mtlb_v = 1'b0; mtlb_d = 1'b0; mtlb_g = 1'b0; mtlb_uncached = 1'b0;

      //             ch va            st us k0 asid miss mh pfn      v  d  g  u  paddr         unc ex
      tbl[0]  = mv(0, 32'h8000_0100, 0, 0, 0, 5, 0, 0, 20'h0,     0, 0, 0, 0, 32'h0000_0100, 0, 0);
      tbl[1]  = mv(0, 32'hA000_0200, 0, 0, 0, 5, 0, 0, 20'h0,     0, 0, 0, 0, 32'h0000_0200, 1, 0);
      tbl[2]  = mv(0, 32'h0040_1234, 0, 0, 0, 5, 1, 1, 20'h12345, 1, 1, 0, 0, 32'h1234_5234, 0, 0);
      tbl[3]  = mv(0, 32'h0040_1ABC, 0, 0, 0, 5, 0, 0, 20'h0,     0, 0, 0, 0, 32'h1234_5ABC, 0, 0);
      tbl[4]  = mv(0, 32'h0040_2000, 0, 0, 0, 5, 1, 0, 20'h0,     0, 0, 0, 0, 32'h0,         0, REF);
      tbl[5]  = mv(0, 32'h0040_3000, 0, 0, 0, 5, 1, 1, 20'h33333, 0, 0, 0, 0, 32'h0,         0, INV);
      tbl[6]  = mv(0, 32'h0040_4010, 1, 0, 0, 5, 1, 1, 20'h00ABC, 1, 0, 0, 1, 32'h00AB_C010, 1, MOD);
      tbl[7]  = mv(0, 32'h0040_4020, 1, 0, 0, 5, 0, 0, 20'h0,     0, 0, 0, 0, 32'h00AB_C020, 1, MOD);
      tbl[8]  = mv(0, 32'h8000_0000, 0, 1, 0, 5, 0, 0, 20'h0,     0, 0, 0, 0, 32'h0,         0, ILL);
      tbl[9]  = mv(1, 32'h0040_1000, 0, 0, 0, 5, 1, 1, 20'h22222, 1, 1, 1, 0, 32'h2222_2000, 0, 0);
      tbl[10] = mv(1, 32'h8000_0300, 0, 0, 1, 5, 0, 0, 20'h0,     0, 0, 0, 0, 32'h0000_0300, 1, 0);
      tbl[11] = mv(1, 32'hC000_0000, 0, 0, 0, 5, 1, 0, 20'h0,     0, 0, 0, 0, 32'h0,         0, REF);
      tbl[12] = mv(1, 32'h0040_1004, 0, 0, 0, 6, 0, 0, 20'h0,     0, 0, 0, 0, 32'h2222_2004, 0, 0);
      tbl[13] = mv(0, 32'h0040_1000, 0, 0, 0, 6, 1, 1, 20'h33333, 1, 1, 0, 0, 32'h3333_3000, 0, 0);
      tbl[14] = mv(0, 32'h0040_1008, 0, 0, 0, 6, 0, 0, 20'h0,     0, 0, 0, 0, 32'h3333_3008, 0, 0);
      tbl[15] = mv(0, 32'h0040_1008, 0, 0, 0, 5, 0, 0, 20'h0,     0, 0, 0, 0, 32'h1234_5008, 0, 0);
      tbl[16] = mv(0, 32'h0040_1000, 0, 1, 0, 5, 0, 0, 20'h0,     0, 0, 0, 0, 32'h1234_5000, 0, 0);

      do_reset();
      for (int i = 0; i < 17; i++) run_vec(tbl[i], 0);
      is_user_mode = 1'b0; kseg0_uncached = 1'b0; asid = 8'h05;

      // back-to-back unmapped requests: one result per cycle
      req_drive(0, 32'h8000_0100, 1'b0);
      push_exp(0, 32'h0000_0100, 1'b0, 4'h0, cyc + 2);
      push_exp(0, 32'h0000_0200, 1'b1, 4'h0, cyc + 3);
      tick();
      req_drive(0, 32'hA000_0200, 1'b0);
      tick();
      ch_req = '0;
      tick(); tick();
      chk("stream_drained", sb.size(), 32'd0);

      // flush in the ack cycle, then flush while the lookup is outstanding
      for (int f = 1; f <= 2; f++) begin
         logic [31:0] va;
         va = (f == 1) ? 32'h0050_0000 : 32'h0051_0000;
         req_drive(0, va, 1'b0);
         tick();
         ch_req = '0;
         serve(0, va, 3, 1'b1, 20'h55555, 1'b1, 1'b1, 1'b0, 1'b0, {20'h55555, va[11:0]}, 1'b0, 4'h0, f);
         tick();
         run_vec(mv(0, va, 0, 0, 0, 5, 1, 0, 20'h0, 0, 0, 0, 0, 32'h0, 0, REF), 0);
      end

      // reset while channel 0 waits on the main TLB; the late ack must be ignored
      req_drive(0, 32'h0070_1000, 1'b0);
      tick();
      ch_req = '0;
      wait_req();
      do_reset();
      mtlb_ack = 1'b1; mtlb_hit = 1'b1; mtlb_v = 1'b1; mtlb_pfn = 20'h77777;
      tick();
      mtlb_ack = 1'b0; mtlb_hit = 1'b0; mtlb_v = 1'b0; mtlb_pfn = '0;
      tick(); tick();
      chk("post_rst_mtlb_req", 32'(mtlb_req), 32'd0);
      chk("post_rst_ready", 32'(ch_ready), 32'h3);
      run_vec(mv(0, 32'h0040_1234, 0, 0, 0, 5, 1, 0, 20'h0, 0, 0, 0, 0, 32'h0, 0, REF), 0);
      run_vec(mv(1, 32'h0040_1000, 0, 0, 0, 5, 1, 0, 20'h0, 0, 0, 0, 0, 32'h0, 0, REF), 0);

      // replacement: five fills into four entries evict the first page
      for (int k = 0; k < 5; k++)
         run_vec(mv(0, 32'h0001_0044 + (k << 12), 0, 0, 0, 5, 1, 1, 20'h00100 + 20'(k), 1, 1, 0, 0,
                    ((32'h100 + k) << 12) | 32'h44, 0, 0), 0);
      for (int k = 1; k < 5; k++)
         run_vec(mv(0, 32'h0001_0044 + (k << 12), 0, 0, 0, 5, 0, 0, 20'h0, 0, 0, 0, 0,
                    ((32'h100 + k) << 12) | 32'h44, 0, 0), 0);
      run_vec(mv(0, 32'h0001_0044, 0, 0, 0, 5, 1, 0, 20'h0, 0, 0, 0, 0, 32'h0, 0, REF), 0);

      // arbitration from a fresh pointer
      do_reset();
      req_drive(0, 32'h0060_0010, 1'b0);
      req_drive(1, 32'h0061_0020, 1'b0);
      tick();
      ch_req = '0;
      serve(0, 32'h0060_0010, 3, 1'b1, 20'h60600, 1'b1, 1'b1, 1'b0, 1'b0, 32'h6060_0010, 1'b0, 4'h0, 0);
      serve(1, 32'h0061_0020, 3, 1'b1, 20'h61610, 1'b1, 1'b1, 1'b0, 1'b0, 32'h6161_0020, 1'b0, 4'h0, 0);
      tick(); tick();
      run_vec(mv(0, 32'h0062_0000, 0, 0, 0, 5, 1, 0, 20'h0, 0, 0, 0, 0, 32'h0, 0, REF), 0);
      req_drive(0, 32'h0063_0030, 1'b0);
      req_drive(1, 32'h0064_0040, 1'b0);
      tick();
      ch_req = '0;
      serve(1, 32'h0064_0040, 3, 1'b1, 20'h64640, 1'b1, 1'b1, 1'b0, 1'b0, 32'h6464_0040, 1'b0, 4'h0, 0);
      serve(0, 32'h0063_0030, 3, 1'b1, 20'h63630, 1'b1, 1'b1, 1'b0, 1'b0, 32'h6363_0030, 1'b0, 4'h0, 0);
      tick(); tick();
      chk("arb_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
